// File: rtl/ship_ctl_multi_if.sv
// Ship controller bus: move/fire/enemy inputs, ship and shot state outputs.
// slave = controller side, master = driver/consumer side.
interface ship_ctl_multi_if #(
  parameter int N_EN    = 3,
  parameter int N_SHOTS = 2
);
  logic                   frame_tick;
  logic                   left;
  logic                   right;
  logic                   fire;
  logic [11*N_EN-1:0]     en_x;
  logic [11*N_EN-1:0]     en_y;
  logic [N_EN-1:0]        en_on;
  logic [N_SHOTS-1:0]     shot_kill;
  logic [10:0]            xpos_ship;
  logic                   ship_vis;
  logic [2:0]             lives;
  logic                   hit_pulse;
  logic                   game_over;
  logic [11*N_SHOTS-1:0]  shot_x;
  logic [11*N_SHOTS-1:0]  shot_y;
  logic [N_SHOTS-1:0]     shot_on;

  modport slave (
    input  frame_tick, left, right, fire,
    input  en_x, en_y, en_on, shot_kill,
    output xpos_ship, ship_vis, lives, hit_pulse,
    output game_over, shot_x, shot_y, shot_on
  );

  modport master (
    output frame_tick, left, right, fire,
    output en_x, en_y, en_on, shot_kill,
    input  xpos_ship, ship_vis, lives, hit_pulse,
    input  game_over, shot_x, shot_y, shot_on
  );
endinterface

// File: rtl/ship_ctl_multi.sv
// Player ship controller: movement, lives, invulnerability, shots.
// Ports: pclk, rst (async active-low), bus (ship_ctl_multi_if.slave).
module ship_ctl_multi #(
  parameter int N_EN     = 3,
  parameter int N_SHOTS  = 2,
  parameter int LIVES    = 3,
  parameter int SHIP_Y   = 680,
  parameter int SHIP_W   = 64,
  parameter int SHIP_H   = 48,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 960,
  parameter int STEP     = 4,
  parameter int SHOT_SPD = 8,
  parameter int COOLDOWN = 8,
  parameter int INV_FR   = 120
) (
  input logic pclk,
  input logic rst,
  ship_ctl_multi_if.slave bus
);

  localparam int IW = $clog2(INV_FR + 1);
  localparam int CW = $clog2(COOLDOWN + 1);

  localparam logic [11:0] XMIN12 = 12'(X_MIN);
  localparam logic [11:0] XMAX12 = 12'(X_MAX);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [11:0] SW12   = 12'(SHIP_W);
  localparam logic [11:0] SY12   = 12'(SHIP_Y);
  localparam logic [11:0] SH12   = 12'(SHIP_H);

  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] HALF11 = 11'(SHIP_W / 2);
  localparam logic [10:0] LDY11  = 11'(SHIP_Y - 1);
  localparam logic [10:0] SPD11  = 11'(SHOT_SPD);
  localparam logic [10:0] XRST11 = 11'((X_MIN + X_MAX) / 2);

  typedef enum logic [1:0] {
    S_ALIVE,
    S_INV,
    S_OVER
  } state_t;

  state_t state_q, state_d;

  logic [10:0]           xpos_q, xpos_d;
  logic [2:0]            lives_q, lives_d;
  logic [IW-1:0]         inv_q, inv_d;
  logic [CW-1:0]         cool_q, cool_d;
  logic                  fire_q, fire_d;
  logic                  hit_q, hit_d;
  logic [11*N_SHOTS-1:0] sx_q, sx_d;
  logic [11*N_SHOTS-1:0] sy_q, sy_d;
  logic [N_SHOTS-1:0]    son_q, son_d;

  logic                  hit_any;
  logic                  hit_acc;
  logic                  to_over;
  logic                  fire_ok;
  logic                  found;
  logic [N_SHOTS-1:0]    free;
  logic [N_SHOTS-1:0]    load;
  logic [11:0]           ex, ey;
  logic [10:0]           y;
  logic                  ship_vis;
  logic                  game_over;

  // Box test in 12 bits so xpos+SHIP_W cannot wrap.
  always_comb begin
    hit_any = 1'b0;
    ex      = '0;
    ey      = '0;
    for (int k = 0; k < N_EN; k++) begin
      ex = {1'b0, bus.en_x[11*k +: 11]};
      ey = {1'b0, bus.en_y[11*k +: 11]};
      if (bus.en_on[k] &&
          ex >= {1'b0, xpos_q} &&
          ex < {1'b0, xpos_q} + SW12 &&
          ey >= SY12 &&
          ey < SY12 + SH12)
        hit_any = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= S_ALIVE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ALIVE:
        if (hit_any)
          state_d = (lives_q > 3'd1) ? S_INV : S_OVER;
      S_INV:
        if (bus.frame_tick && inv_q == IW'(1))
          state_d = S_ALIVE;
      default: state_d = S_OVER;
    endcase
  end

  always_comb begin
    ship_vis  = 1'b1;
    game_over = 1'b0;
    unique case (1'b1)
      state_q == S_INV:  ship_vis = inv_q[3];
      state_q == S_OVER: begin
        ship_vis  = 1'b0;
        game_over = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_acc = (state_q == S_ALIVE) && hit_any;
    to_over = (state_d == S_OVER) && (state_q != S_OVER);
    hit_d   = hit_acc;
    lives_d = lives_q;
    inv_d   = inv_q;
    xpos_d  = xpos_q;
    cool_d  = cool_q;
    fire_d  = bus.fire;
    sx_d    = sx_q;
    sy_d    = sy_q;
    son_d   = son_q;
    y       = '0;

    if (hit_acc) lives_d = lives_q - 3'd1;

    if (state_q == S_ALIVE && state_d == S_INV)
      inv_d = IW'(INV_FR);
    else if (state_q == S_INV && bus.frame_tick)
      inv_d = inv_q - IW'(1);

    if (bus.frame_tick && state_q != S_OVER &&
        (bus.left ^ bus.right)) begin
      if (bus.left)
        xpos_d = ({1'b0, xpos_q} < XMIN12 + STEP12) ?
                 XMIN11 : xpos_q - STEP11;
      else
        xpos_d = ({1'b0, xpos_q} + STEP12 > XMAX12) ?
                 XMAX11 : xpos_q + STEP11;
    end

    // A slot being killed this cycle is not offered for loading.
    free    = ~son_q & ~bus.shot_kill;
    fire_ok = bus.fire && !fire_q &&
              state_q != S_OVER &&
              cool_q == '0 && (|free);

    load  = '0;
    found = 1'b0;
    for (int k = 0; k < N_SHOTS; k++) begin
      if (fire_ok && free[k] && !found) begin
        load[k] = 1'b1;
        found   = 1'b1;
      end
    end

    if (fire_ok)
      cool_d = CW'(COOLDOWN);
    else if (bus.frame_tick && cool_q != '0)
      cool_d = cool_q - CW'(1);

    for (int k = 0; k < N_SHOTS; k++) begin
      y = sy_q[11*k +: 11];
      if (to_over) begin
        son_d[k] = 1'b0;
      end else if (state_q == S_OVER) begin
        son_d[k] = son_q[k];
      end else if (bus.shot_kill[k]) begin
        son_d[k] = 1'b0;
      end else if (load[k]) begin
        sx_d[11*k +: 11] = xpos_q + HALF11;
        sy_d[11*k +: 11] = LDY11;
        son_d[k]         = 1'b1;
      end else if (bus.frame_tick && son_q[k]) begin
        if (y >= SPD11) sy_d[11*k +: 11] = y - SPD11;
        else            son_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      xpos_q  <= XRST11;
      lives_q <= 3'(LIVES);
      inv_q   <= '0;
      cool_q  <= '0;
      fire_q  <= 1'b0;
      hit_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      son_q   <= '0;
    end else begin
      xpos_q  <= xpos_d;
      lives_q <= lives_d;
      inv_q   <= inv_d;
      cool_q  <= cool_d;
      fire_q  <= fire_d;
      hit_q   <= hit_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      son_q   <= son_d;
    end
  end

  assign bus.xpos_ship = xpos_q;
  assign bus.ship_vis  = ship_vis;
  assign bus.lives     = lives_q;
  assign bus.hit_pulse = hit_q;
  assign bus.game_over = game_over;
  assign bus.shot_x    = sx_q;
  assign bus.shot_y    = sy_q;
  assign bus.shot_on   = son_q;

endmodule
